// File: rtl/seq_divider_10by5.sv
// Restoring divider: 10-bit unsigned dividend / 5-bit unsigned divisor, one quotient bit per clock.
// state | meaning: IDLE | waiting for start; CALC | one restoring step per edge; ZERO | divide-by-zero result
module seq_divider_10by5 #(
  parameter int DIVIDEND_W = 10,
  parameter int DIVISOR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DIVIDEND_W-1:0] dvd_sh;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVISOR_W-1:0]  part;
  logic [CNT_W-1:0]      cnt;

  logic                  load;
  logic                  step;
  logic                  fin_calc;
  logic                  fin_zero;
  logic [DIVISOR_W:0]    trial;
  logic                  ge;
  logic [DIVISOR_W-1:0]  part_nxt;
  logic [DIVIDEND_W-1:0] dvd_sh_nxt;

  // Quotient bits shift into the low end of the dividend register as its MSBs are consumed.
  always_comb begin
    trial      = {part, dvd_sh[DIVIDEND_W-1]};
    ge         = (trial >= {1'b0, dsr});
    part_nxt   = ge ? DIVISOR_W'(trial - {1'b0, dsr}) : trial[DIVISOR_W-1:0];
    dvd_sh_nxt = {dvd_sh[DIVIDEND_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin_calc  = 1'b0;
    fin_zero  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (divisor == '0) ? ZERO : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == '0) begin
          fin_calc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      ZERO: begin
        fin_zero  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Down-counter: loaded with DIVIDEND_W-1, the step that sees zero is the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh <= '0;
      dsr    <= '0;
      part   <= '0;
      cnt    <= '0;
    end else if (load) begin
      dvd_sh <= dividend;
      dsr    <= divisor;
      part   <= '0;
      cnt    <= CNT_W'(DIVIDEND_W - 1);
    end else if (step) begin
      dvd_sh <= dvd_sh_nxt;
      part   <= part_nxt;
      cnt    <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= fin_calc | fin_zero;
      if (fin_calc) begin
        quotient    <= dvd_sh_nxt;
        remainder   <= part_nxt;
        div_by_zero <= 1'b0;
      end else if (fin_zero) begin
        quotient    <= '1;
        remainder   <= '0;
        div_by_zero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_10by5.sv
// Directed bench for seq_divider_10by5: table of operand/result vectors plus handshake and reset corners.
module tb_seq_divider_10by5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] dividend = '0;
  logic [4:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [9:0] quotient;
  logic [4:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider_10by5 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] dd;
    logic [4:0] ds;
    int         q;
    int         r;
    int         dbz;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [9:0] dd, input logic [4:0] ds);
    @(negedge clk);
    dividend = dd;
    divisor  = ds;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 10'($urandom);
    divisor  = 5'($urandom);
    check("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_done(input int so_far, output int lat);
    lat = so_far;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) return;
      check("busy_while_running", int'(busy), 1);
    end
    check("done_timeout", int'(done), 1);
  endtask

  task automatic check_result(input string tag, input int q, input int r, input int dbz);
    check({tag, "_quotient"}, int'(quotient), q);
    check({tag, "_remainder"}, int'(remainder), r);
    check({tag, "_div_by_zero"}, int'(div_by_zero), dbz);
    check({tag, "_busy_at_done"}, int'(busy), 0);
  endtask

  initial begin
    int lat;
    int done_seen;

    vecs[0] = '{10'd1023, 5'd31, 33,   0, 0, 10};
    vecs[1] = '{10'd100,  5'd7,  14,   2, 0, 10};
    vecs[2] = '{10'd5,    5'd9,  0,    5, 0, 10};
    vecs[3] = '{10'd0,    5'd1,  0,    0, 0, 10};
    vecs[4] = '{10'd200,  5'd0,  1023, 0, 1, 1};
    vecs[5] = '{10'd6,    5'd3,  2,    0, 0, 10};
    vecs[6] = '{10'd1000, 5'd3,  333,  1, 0, 10};
    vecs[7] = '{10'd31,   5'd31, 1,    0, 0, 10};
    vecs[8] = '{10'd1023, 5'd1,  1023, 0, 0, 10};
    vecs[9] = '{10'd512,  5'd17, 30,   2, 0, 10};

    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_div_by_zero", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].dd, vecs[i].ds);
      wait_done(0, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_one_cycle", i), int'(done), 0);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    start_op(10'd100, 5'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 10'd50;
    divisor  = 5'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignored_start_busy", int'(busy), 1);
    wait_done(4, lat);
    check("ignored_start_latency", lat, 10);
    check_result("ignored_start", 14, 2, 0);
    start    = 1'b1;
    dividend = 10'd50;
    divisor  = 5'd5;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 10'd999;
    divisor  = 5'd2;
    check("b2b_done_dropped", int'(done), 0);
    check("b2b_busy", int'(busy), 1);
    wait_done(0, lat);
    check("b2b_latency", lat, 10);
    check_result("b2b", 10, 0, 0);

    // Leave non-zero flags, then reset in the middle of an operation.
    start_op(10'd200, 5'd0);
    wait_done(0, lat);
    check("pre_reset_dbz", int'(div_by_zero), 1);
    start_op(10'd1000, 5'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_quotient", int'(quotient), 0);
    check("midreset_remainder", int'(remainder), 0);
    check("midreset_div_by_zero", int'(div_by_zero), 0);
    done_seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done) done_seen = 1;
    end
    check("midreset_no_done", done_seen, 0);
    check("midreset_idle_busy", int'(busy), 0);
    start_op(10'd1000, 5'd3);
    wait_done(0, lat);
    check("post_reset_latency", lat, 10);
    check_result("post_reset", 333, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
